// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down-counting timer.
package down_counter_pkg;

    localparam int DC_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } dc_state_e;

endpackage

// File: rtl/down_counter_core.sv
// Datapath for the down-counting timer: count and reload registers, decrementer, zero detect.
module down_counter_core
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             ret,
    input  logic             load,
    input  logic             pre,
    input  logic             dec,
    input  logic             reload,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             one,
    output logic             rld_zero
);

    logic [WIDTH-1:0] rld;

    // Preset outranks load; the decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            y   <= '0;
            rld <= '0;
        end else if (pre) begin
            y   <= '1;
            rld <= '1;
        end else if (load) begin
            y   <= a;
            rld <= a;
        end else if (reload) begin
            y   <= rld;
        end else if (dec && !zero) begin
            y   <= y - WIDTH'(1);
        end
    end

    assign zero     = (y == '0);
    assign one      = (y == WIDTH'(1));
    assign rld_zero = (rld == '0);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counting interval/timeout timer with one-cycle terminal-count pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to make RUN reload from the last loaded value after zero.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             ret,
    input  logic             load,
    input  logic             pre,
    input  logic [WIDTH-1:0] a,
    input  logic             start,
    input  logic             stop,
    input  logic             ce,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             busy
);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    dc_state_e state, state_next;
    logic      dec, reload, tc_next;
    logic      zero, one, rld_zero;
    logic      keep_running;

    down_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .ret     (ret),
        .load    (load),
        .pre     (pre),
        .dec     (dec),
        .reload  (reload),
        .a       (a),
        .y       (y),
        .zero    (zero),
        .one     (one),
        .rld_zero(rld_zero)
    );

    // A zero reload value can never restart, so it finishes like the one-shot.
    assign keep_running = AUTO_RELOAD && !rld_zero;

    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            state <= IDLE;
            tc    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            tc    <= tc_next;
            busy  <= (state_next == RUN) || (state_next == HOLD);
        end
    end

    // Priority per edge: pre > load > stop > start > decrement.
    always_comb begin
        state_next = state;
        dec        = 1'b0;
        reload     = 1'b0;
        tc_next    = 1'b0;
        if (pre || load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!stop && start && !zero) state_next = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_next = HOLD;
                    end else if (zero) begin
                        if (keep_running) reload = 1'b1;
                        else              state_next = DONE;
                    end else if (ce) begin
                        dec = 1'b1;
                        if (one) begin
                            tc_next = 1'b1;
                            if (!keep_running) state_next = DONE;
                        end
                    end
                end
                HOLD: begin
                    if (!stop && start) state_next = RUN;
                end
                DONE: begin
                    state_next = DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed scoreboard bench for down_counter_timer; expectations are hand-derived constants.
module tb_down_counter_timer;

    logic       clk;
    logic       ret;
    logic       load, pre, start, stop, ce;
    logic [3:0] a;
    logic [3:0] y;
    logic       tc, busy;

    typedef struct {
        logic [3:0] y;
        logic       tc;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    down_counter_timer #(
        .WIDTH(4)
    ) dut (
        .clk  (clk),
        .ret  (ret),
        .load (load),
        .pre  (pre),
        .a    (a),
        .start(start),
        .stop (stop),
        .ce   (ce),
        .y    (y),
        .tc   (tc),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushExpect(input logic [3:0] ey, input logic etc, input logic ebusy,
                              input string tag);
        exp_t e;
        e.y    = ey;
        e.tc   = etc;
        e.busy = ebusy;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty got no expectation want one");
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (y === e.y) else begin
            miscompares++;
            $error("[TB] FAIL %s y got %0d want %0d", e.tag, y, e.y);
        end
        assert (tc === e.tc) else begin
            miscompares++;
            $error("[TB] FAIL %s tc got %b want %b", e.tag, tc, e.tc);
        end
        assert (busy === e.busy) else begin
            miscompares++;
            $error("[TB] FAIL %s busy got %b want %b", e.tag, busy, e.busy);
        end
    endtask

    // Drive one edge worth of inputs, record what the edge must produce, sample 1 after it.
    task automatic applyStimulus(input logic ld, input logic pr, input logic st,
                                 input logic sp, input logic c, input logic [3:0] av,
                                 input logic [3:0] ey, input logic etc, input logic ebusy,
                                 input string tag);
        load  = ld;
        pre   = pr;
        start = st;
        stop  = sp;
        ce    = c;
        a     = av;
        pushExpect(ey, etc, ebusy, tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        ret   = 1'b0;
        load  = 1'b0;
        pre   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        ce    = 1'b0;
        a     = 4'd0;
        #12;
        pushExpect(4'd0, 1'b0, 1'b0, "reset");
        checkOutput();
        ret = 1'b1;

        $display("[TB] load 3, run to zero");
        applyStimulus(1, 0, 0, 0, 0, 4'd3, 4'd3, 0, 0, "t2_load");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd3, 0, 1, "t2_start");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd2, 0, 1, "t2_dec2");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd1, 0, 1, "t2_dec1");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 1, 0, "t2_zero");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "t2_done");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd0, 0, 0, "t2_done_start");

        $display("[TB] pause and resume");
        applyStimulus(1, 0, 0, 0, 0, 4'd6, 4'd6, 0, 0, "t3_load");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd6, 0, 1, "t3_start");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd5, 0, 1, "t3_dec5");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd4, 0, 1, "t3_dec4");
        applyStimulus(0, 0, 0, 1, 1, 4'd0, 4'd4, 0, 1, "t3_stop");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd4, 0, 1, "t3_hold1");
        applyStimulus(0, 0, 0, 1, 1, 4'd0, 4'd4, 0, 1, "t3_hold2");
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd4, 0, 1, "t3_hold3");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd4, 0, 1, "t3_resume");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd3, 0, 1, "t3_dec3");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd2, 0, 1, "t3_dec2");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd1, 0, 1, "t3_dec1");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 1, 0, "t3_zero");

        $display("[TB] start/stop collision and gated enable");
        applyStimulus(1, 0, 0, 0, 0, 4'd2, 4'd2, 0, 0, "t4_load");
        applyStimulus(0, 0, 1, 1, 1, 4'd0, 4'd2, 0, 0, "t4_both_idle");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd2, 0, 0, "t4_idle_ce");
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd2, 0, 1, "t4_start");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd1, 0, 1, "t4_ce1");
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd1, 0, 1, "t4_ce0");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 1, 0, "t4_zero");

        $display("[TB] async reset mid-count");
        applyStimulus(1, 0, 0, 0, 0, 4'd5, 4'd5, 0, 0, "t1_load");
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd5, 0, 1, "t1_start");
        applyStimulus(0, 0, 1, 1, 1, 4'd0, 4'd5, 0, 1, "t1_both_run");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd5, 0, 1, "t1_resume");
        start = 1'b0;
        #3;
        ret = 1'b0;
        #1;
        pushExpect(4'd0, 1'b0, 1'b0, "t1_async");
        checkOutput();
        #2;
        ret = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "t1_after");

        $display("[TB] preset and zero start");
        applyStimulus(1, 0, 0, 0, 0, 4'd4, 4'd4, 0, 0, "t5_load");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd4, 0, 1, "t5_start");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd3, 0, 1, "t5_dec3");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd2, 0, 1, "t5_dec2");
        applyStimulus(0, 1, 0, 0, 1, 4'd0, 4'd15, 0, 0, "t5_pre");
        applyStimulus(1, 1, 0, 0, 0, 4'd3, 4'd15, 0, 0, "t5_pre_over_load");
        applyStimulus(1, 0, 0, 0, 0, 4'd1, 4'd1, 0, 0, "t5_load1");
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd1, 0, 1, "t5_start1");
        applyStimulus(0, 1, 0, 0, 1, 4'd0, 4'd15, 0, 0, "t5_pre_no_tc");
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "t5_load0");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd0, 0, 0, "t5_start0");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "t5_idle0");

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        $display("[TB] auto reload");
        applyStimulus(1, 0, 0, 0, 0, 4'd2, 4'd2, 0, 0, "t6_load");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd2, 0, 1, "t6_start");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd1, 0, 1, "t6_dec1");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 1, 1, "t6_zero1");
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd2, 0, 1, "t6_reload1");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd1, 0, 1, "t6_dec1b");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 1, 1, "t6_zero2");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd2, 0, 1, "t6_reload2");
        applyStimulus(0, 0, 0, 1, 1, 4'd0, 4'd2, 0, 1, "t6_stop");
        applyStimulus(1, 0, 0, 0, 0, 4'd3, 4'd3, 0, 0, "t6_load_exit");
`else
        $display("[TB] one-shot");
        applyStimulus(1, 0, 0, 0, 0, 4'd2, 4'd2, 0, 0, "t6_load");
        applyStimulus(0, 0, 1, 0, 1, 4'd0, 4'd2, 0, 1, "t6_start");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd1, 0, 1, "t6_dec1");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 1, 0, "t6_zero");
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "t6_no_reload");
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "t6_no_wrap");
`endif

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
